// File: rtl/vga_pkg.sv
// Shared VGA receiver types: palette codes, palette RGB values, default timing, pixel decode.
package vga_pkg;

  typedef enum logic [1:0] {
    BLACK = 2'd0,
    WHITE = 2'd1,
    BLUE  = 2'd2,
    GREEN = 2'd3
  } color_e;

  // Pixel layout is {B[3:0], G[3:0], R[3:0]}.
  localparam logic [11:0] RgbBlack = 12'h000;
  localparam logic [11:0] RgbWhite = 12'hFFF;
  localparam logic [11:0] RgbBlue  = 12'hF00;
  localparam logic [11:0] RgbGreen = 12'h0F0;

  // 1280x1024 default timing: display, front porch, sync, back porch.
  localparam int unsigned DefHd = 1280;
  localparam int unsigned DefHf = 48;
  localparam int unsigned DefHr = 112;
  localparam int unsigned DefHb = 248;
  localparam int unsigned DefVd = 1024;
  localparam int unsigned DefVf = 1;
  localparam int unsigned DefVr = 3;
  localparam int unsigned DefVb = 38;

  typedef struct packed {
    color_e color;
    logic   bad;
  } decode_t;

  // Out-of-palette values decode to BLACK and raise the bad flag.
  function automatic decode_t decode_rgb(logic [11:0] rgb);
    decode_t res;
    res.color = BLACK;
    res.bad   = 1'b0;
    case (rgb)
      RgbBlack: res.color = BLACK;
      RgbWhite: res.color = WHITE;
      RgbBlue:  res.color = BLUE;
      RgbGreen: res.color = GREEN;
      default:  res.bad   = 1'b1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/vga_edge_det.sv
// Input-stage register for a sync line plus rising-edge detect on the registered copy.
module vga_edge_det (
  input  logic clk,
  input  logic arstn,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic level_q, level_d;
  logic prev_q, prev_d;

  // Next state: capture the pin, then remember the previous registered level.
  always_comb begin
    level_d = d_i;
    prev_d  = level_q;
  end

  // State registers.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      level_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      prev_q  <= prev_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = level_q & ~prev_q;

endmodule

// File: rtl/vga_rx.sv
// VGA receiver: locks onto hs/vs timing, then emits display pixels with coordinates and palette code.
module vga_rx
  import vga_pkg::*;
#(
  parameter int unsigned HSYNC_BITS = 11,
  parameter int unsigned VSYNC_BITS = 11,
  parameter int unsigned HD = DefHd,
  parameter int unsigned HF = DefHf,
  parameter int unsigned HR = DefHr,
  parameter int unsigned HB = DefHb,
  parameter int unsigned VD = DefVd,
  parameter int unsigned VF = DefVf,
  parameter int unsigned VR = DefVr,
  parameter int unsigned VB = DefVb
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  vga_hs_i,
  input  logic                  vga_vs_i,
  input  logic [11:0]           rgb_i,
  output logic                  pix_valid_o,
  output logic [HSYNC_BITS-1:0] pix_x_o,
  output logic [VSYNC_BITS-1:0] pix_y_o,
  output logic [11:0]           rgb_o,
  output logic [1:0]            color_o,
  output logic                  bad_color_o,
  output logic                  locked_o,
  output logic                  frame_start_o,
  output logic                  err_o
);

  localparam int unsigned HTOTAL = HD + HF + HR + HB;
  localparam int unsigned VTOTAL = VD + VF + VR + VB;
  localparam int unsigned HSTART = HR + HB;
  localparam int unsigned VSTART = VR + VB;

  localparam logic [HSYNC_BITS-1:0] HMax  = '1;
  localparam logic [VSYNC_BITS-1:0] VMax  = '1;
  localparam logic [HSYNC_BITS-1:0] HLast = HSYNC_BITS'(HTOTAL - 1);
  localparam logic [VSYNC_BITS-1:0] VLast = VSYNC_BITS'(VTOTAL - 1);

  typedef enum logic [1:0] {StUnlocked, StAcquire, StLocked} state_e;

  logic hs_lvl_unused, hs_rise, vs_lvl, vs_rise;
  logic [11:0] rgb_in_q;

  logic [HSYNC_BITS-1:0] hcnt_q, hcnt_d;
  logic [VSYNC_BITS-1:0] vcnt_q, vcnt_d;

  state_e state_q, state_d;
  logic   acq_fail_q, acq_fail_d;
  logic   locked_q, locked_d;
  logic   err_q, err_d;

  logic line_fail, frame_fail, hsat;

  logic                  in_win, h_in, v_in;
  logic [HSYNC_BITS-1:0] win_x;
  logic [VSYNC_BITS-1:0] win_y;
  decode_t               dec;

  logic                  pix_valid_q, pix_valid_d;
  logic [HSYNC_BITS-1:0] pix_x_q, pix_x_d;
  logic [VSYNC_BITS-1:0] pix_y_q, pix_y_d;
  logic [11:0]           rgb_q, rgb_d;
  color_e                color_q, color_d;
  logic                  bad_color_q, bad_color_d;
  logic                  frame_start_q, frame_start_d;

  vga_edge_det u_hs_det (
    .clk     (clk),
    .arstn   (arstn),
    .d_i     (vga_hs_i),
    .level_o (hs_lvl_unused),
    .rise_o  (hs_rise)
  );

  vga_edge_det u_vs_det (
    .clk     (clk),
    .arstn   (arstn),
    .d_i     (vga_vs_i),
    .level_o (vs_lvl),
    .rise_o  (vs_rise)
  );

  // Line/column counters; hcnt_d is the column of the pixel now in rgb_in_q, hcnt_q the one before.
  always_comb begin
    if (hs_rise) begin
      hcnt_d = '0;
    end else if (hcnt_q == HMax) begin
      hcnt_d = HMax;
    end else begin
      hcnt_d = hcnt_q + 1'b1;
    end
    vcnt_d = vcnt_q;
    if (hs_rise) begin
      if (vs_rise || (vs_lvl && (vcnt_q >= VLast))) begin
        vcnt_d = '0;
      end else if (vcnt_q != VMax) begin
        vcnt_d = vcnt_q + 1'b1;
      end
    end
  end

  assign line_fail  = hs_rise && (hcnt_q != HLast);
  assign frame_fail = vs_rise && (vcnt_q != VLast);
  assign hsat       = !hs_rise && (hcnt_q == HMax);

  // Lock FSM next state: one clean frame between two vs edges is required to lock.
  always_comb begin
    state_d    = state_q;
    acq_fail_d = acq_fail_q;
    err_d      = 1'b0;
    unique case (state_q)
      StUnlocked: begin
        if (vs_rise) begin
          state_d    = StAcquire;
          acq_fail_d = 1'b0;
        end
      end
      StAcquire: begin
        if (vs_rise) begin
          // A line failure on the same edge blocks the lock.
          if (!line_fail && !frame_fail && !acq_fail_q) begin
            state_d = StLocked;
          end
          acq_fail_d = 1'b0;
        end else if (line_fail) begin
          acq_fail_d = 1'b1;
        end
      end
      StLocked: begin
        if (line_fail || frame_fail || hsat) begin
          state_d = StUnlocked;
          err_d   = 1'b1;
        end
      end
      default: state_d = StUnlocked;
    endcase
    locked_d = (state_d == StLocked);
  end

  // Display window and pixel output next state; coordinates and data hold outside the window.
  always_comb begin
    h_in   = (32'(hcnt_d) >= HSTART) && (32'(hcnt_d) < HSTART + HD);
    v_in   = (32'(vcnt_d) >= VSTART) && (32'(vcnt_d) < VSTART + VD);
    in_win = (state_q == StLocked) && h_in && v_in;
    win_x  = HSYNC_BITS'(32'(hcnt_d) - HSTART);
    win_y  = VSYNC_BITS'(32'(vcnt_d) - VSTART);
    dec    = decode_rgb(rgb_in_q);

    pix_valid_d   = in_win;
    bad_color_d   = in_win && dec.bad;
    frame_start_d = in_win && (win_x == '0) && (win_y == '0);
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    rgb_d         = rgb_q;
    color_d       = color_q;
    if (in_win) begin
      pix_x_d = win_x;
      pix_y_d = win_y;
      rgb_d   = rgb_in_q;
      color_d = dec.color;
    end
  end

  // All state: input stage, counters, FSM and registered outputs.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      rgb_in_q      <= '0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      state_q       <= StUnlocked;
      acq_fail_q    <= 1'b0;
      locked_q      <= 1'b0;
      err_q         <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      rgb_q         <= '0;
      color_q       <= BLACK;
      bad_color_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      rgb_in_q      <= rgb_i;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      state_q       <= state_d;
      acq_fail_q    <= acq_fail_d;
      locked_q      <= locked_d;
      err_q         <= err_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      rgb_q         <= rgb_d;
      color_q       <= color_d;
      bad_color_q   <= bad_color_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_valid_o   = pix_valid_q;
  assign pix_x_o       = pix_x_q;
  assign pix_y_o       = pix_y_q;
  assign rgb_o         = rgb_q;
  assign color_o       = color_q;
  assign bad_color_o   = bad_color_q;
  assign locked_o      = locked_q;
  assign frame_start_o = frame_start_q;
  assign err_o         = err_q;

endmodule
